fp_add_pipe: RTL and testbench

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

---
 rtl/fp_add_pipe.sv | 187 ++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor.
//   Word layout {sign, exponent[EXP_W], mantissa[MAN_W]}, hidden leading one.
//   Denormal inputs flush to zero, rounding truncates toward zero, and any
//   all-ones exponent input (NaN or infinity) yields the canonical quiet NaN.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a, b and sub are sampled this cycle
//   a, b       operands
//   sub        0: a+b, 1: a-b
//   out        result word (held during bubbles)
//   out_valid  out/ovf carry the result issued three cycles earlier
//   ovf        result overflowed to infinity
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   out_valid,
  output logic                   ovf
);

  localparam int W    = 1 + EXP_W + MAN_W;
  // Extended mantissa: hidden one, MAN_W fraction bits, guard, round, sticky.
  localparam int XW   = MAN_W + 4;
  localparam int LZ_W = $clog2(XW);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EXP_W+1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EONE = {{(EXP_W+1){1'b0}}, 1'b1};

  // Right shift that folds every bit pushed out into the sticky position.
  function automatic logic [XW-1:0] align(input logic [XW-1:0] m,
                                          input logic [EXP_W-1:0] d);
    logic [XW-1:0] sh;
    logic [XW-1:0] lost;
    if (int'(d) >= MAN_W + 3) begin
      align = {{(XW-1){1'b0}}, 1'b1};
    end else begin
      sh    = m >> d;
      lost  = m & ~({XW{1'b1}} << d);
      align = {sh[XW-1:1], sh[0] | (|lost)};
    end
  endfunction

  function automatic logic [LZ_W-1:0] lzc(input logic [XW-1:0] v);
    lzc = '0;
    for (int i = 0; i < XW; i++) begin
      if (v[i]) lzc = LZ_W'(XW - 1 - i);
    end
  endfunction

  // Saturating pack: returns {ovf, word}; underflow gives signed zero,
  // overflow gives signed infinity.
  function automatic logic [W:0] pack(input logic s,
                                      input logic signed [EXP_W+1:0] e,
                                      input logic [MAN_W-1:0] m);
    if (e[EXP_W+1] || e == '0)
      pack = {1'b0, s, {(W-1){1'b0}}};
    else if (e >= EMAX)
      pack = {1'b1, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      pack = {1'b0, s, e[EXP_W-1:0], m};
  endfunction

  logic                   sb;
  logic [EXP_W-1:0]       ea, eb, ebig, esml;
  logic [MAN_W-1:0]       ma, mb;
  logic                   a_big;
  logic                   byp_n;
  logic [W-1:0]           byp_word_n;

  assign sb = b[W-1] ^ sub;
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];

  always_comb begin
    byp_n      = 1'b1;
    byp_word_n = '0;
    if ((&ea) || (&eb))            byp_word_n = QNAN;
    else if (ea == '0 && eb == '0) byp_word_n = '0;
    else if (ea == '0)             byp_word_n = {sb, b[W-2:0]};
    else if (eb == '0)             byp_word_n = a;
    else                           byp_n      = 1'b0;
  end

  assign a_big = a[W-2:0] >= b[W-2:0];
  assign ebig  = a_big ? ea : eb;
  assign esml  = a_big ? eb : ea;

  // ---- stage 1 -> p0: unpack, specials, compare, swap, align ----
  logic                   vld_p0;
  logic                   byp_p0;
  logic [W-1:0]           byp_word_p0;
  logic                   sign_p0;
  logic                   esub_p0;
  logic signed [EXP_W+1:0] exp_p0;
  logic [XW-1:0]          mbig_p0;
  logic [XW-1:0]          msml_p0;

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    byp_p0      <= byp_n;
    byp_word_p0 <= byp_word_n;
    sign_p0     <= a_big ? a[W-1] : sb;
    esub_p0     <= a[W-1] ^ sb;
    exp_p0      <= {2'b00, ebig};
    mbig_p0     <= {1'b1, (a_big ? ma : mb), 3'b000};
    msml_p0     <= align({1'b1, (a_big ? mb : ma), 3'b000}, ebig - esml);
  end

  // ---- stage 2 -> p1: mantissa add/subtract (big >= small, never negative) ----
  logic                   vld_p1;
  logic                   byp_p1;
  logic [W-1:0]           byp_word_p1;
  logic                   sign_p1;
  logic signed [EXP_W+1:0] exp_p1;
  logic [XW:0]            sum_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    byp_p1      <= byp_p0;
    byp_word_p1 <= byp_word_p0;
    sign_p1     <= sign_p0;
    exp_p1      <= exp_p0;
    sum_p1      <= esub_p0 ? ({1'b0, mbig_p0} - {1'b0, msml_p0})
                           : ({1'b0, mbig_p0} + {1'b0, msml_p0});
  end

  // ---- stage 3 -> p2: normalise, truncate, pack ----
  logic [LZ_W-1:0]        lz;
  logic [MAN_W-1:0]       mnrm;
  logic [W:0]             res;

  assign lz   = lzc(sum_p1[XW-1:0]);
  // The leading one falls off the top; guard/round/sticky fall off the bottom.
  assign mnrm = MAN_W'((sum_p1[XW-2:0] << lz) >> 3);

  always_comb begin
    res = '0;
    if (byp_p1)
      res = {1'b0, byp_word_p1};
    else if (sum_p1 == '0)
      res = '0;
    else if (sum_p1[XW])
      res = pack(sign_p1, exp_p1 + EONE, sum_p1[XW-1:4]);
    else
      res = pack(sign_p1, exp_p1 - signed'({{(EXP_W+2-LZ_W){1'b0}}, lz}), mnrm);
  end

  logic                   vld_p2;
  logic [W-1:0]           out_p2;
  logic                   ovf_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      out_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      ovf_p2 <= vld_p1 & res[W];
      if (vld_p1) out_p2 <= res[W-1:0];
    end
  end

  assign out       = out_p2;
  assign out_valid = vld_p2;
  assign ovf       = ovf_p2;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Testbench for fp_add_pipe at default parameters (binary32 layout).
// Expected results are queued when an operation is issued and compared when
// out_valid appears; random operations use an exact wide-integer model.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        sub;
  logic [31:0] out;
  logic        out_valid;
  logic        ovf;

  fp_add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sub(sub),
    .out(out), .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, the sum is
  // formed exactly, then truncated to 24 significant bits.
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic         sy, sr;
    logic [7:0]   ex, ey;
    logic [299:0] vx, vy, mag;
    int           p, e;
    sy = y[31] ^ s;
    ex = x[30:23];
    ey = y[30:23];
    if (ex == 8'hFF || ey == 8'hFF) return {1'b0, 32'h7FC00000};
    if (ex == 8'h00 && ey == 8'h00) return 33'h0;
    if (ex == 8'h00) return {1'b0, sy, y[30:0]};
    if (ey == 8'h00) return {1'b0, x};
    vx = 300'({1'b1, x[22:0]}) << (int'(ex) - 1);
    vy = 300'({1'b1, y[22:0]}) << (int'(ey) - 1);
    if (x[31] == sy) begin
      mag = vx + vy; sr = x[31];
    end else if (vx >= vy) begin
      mag = vx - vy; sr = x[31];
    end else begin
      mag = vy - vx; sr = sy;
    end
    if (mag == '0) return 33'h0;
    p = -1;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0)   return {1'b0, sr, 31'h0};
    if (e >= 255) return {1'b1, sr, 8'hFF, 23'h0};
    mag = mag >> (p - 23);
    return {1'b0, sr, 8'(e), mag[22:0]};
  endfunction

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       input logic [32:0] want);
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    sb_q.push_back('{want[31:0], want[32], cyc});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue_unchecked(input logic [31:0] ia, input logic [31:0] ib);
    a = ia; b = ib; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("latency", cyc - e.cyc, 32'd3);
        check_eq("out", out, e.word);
        check_eq("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    logic        s;
    int          ex, ey, mode, t;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out", out, 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    issue(32'h41700000, 32'h41A00000, 1'b0, {1'b0, 32'h420C0000});
    repeat (1) @(negedge clk);
    issue(32'h41700000, 32'h41A00000, 1'b1, {1'b0, 32'hC0A00000});
    issue(32'h3F800000, 32'h3F800000, 1'b1, {1'b0, 32'h00000000});
    issue(32'h00000000, 32'hBF800000, 1'b0, {1'b0, 32'hBF800000});
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {1'b1, 32'h7F800000});
    issue(32'h7F800000, 32'h3F800000, 1'b0, {1'b0, 32'h7FC00000});
    issue(32'h00800000, 32'h00C00000, 1'b1, {1'b0, 32'h80000000});
    issue(32'h3F800000, 32'h30800000, 1'b0, {1'b0, 32'h3F800000});
    issue(32'h3F800000, 32'h30800000, 1'b1, {1'b0, 32'h3F7FFFFF});
    issue(32'h00000000, 32'h80000000, 1'b0, {1'b0, 32'h00000000});
    repeat (4) @(negedge clk);

    issue(32'h3F800000, 32'h3F800000, 1'b0, {1'b0, 32'h40000000});
    issue(32'h3F800000, 32'h40000000, 1'b0, {1'b0, 32'h40400000});
    issue(32'h3F800000, 32'h40400000, 1'b0, {1'b0, 32'h40800000});
    issue(32'h3F800000, 32'h40800000, 1'b0, {1'b0, 32'h40A00000});
    repeat (4) @(negedge clk);
    check_eq("bubble_valid", 32'(out_valid), 32'd0);
    check_eq("bubble_known", 32'($isunknown(out)), 32'd0);

    // Two operations in flight, then reset with a simultaneous in_valid.
    issue_unchecked(32'h3F800000, 32'h40000000);
    issue_unchecked(32'h40000000, 32'h40000000);
    rst = 1'b1; in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    issue(32'h40400000, 32'h3F800000, 1'b1, {1'b0, 32'h40000000});
    repeat (4) @(negedge clk);

    for (int i = 0; i < 120; i++) begin
      mode = int'($urandom_range(0, 9));
      ex   = int'($urandom_range(1, 254));
      if (mode < 6) begin
        ey = ex + int'($urandom_range(0, 60)) - 30;
        if (ey < 1) ey = 1;
        if (ey > 254) ey = 254;
      end else if (mode < 8) begin
        ey = int'($urandom_range(1, 254));
      end else if (mode == 8) begin
        ey = ($urandom_range(0, 3) == 0) ? 255 : 0;
      end else begin
        ex = 254;
        ey = 254 - int'($urandom_range(0, 2));
      end
      x = {1'($urandom_range(0, 1)), 8'(ex), 23'($urandom)};
      y = {1'($urandom_range(0, 1)), 8'(ey), 23'($urandom)};
      if (i % 2 == 1) begin
        x = y;
        y = {1'($urandom_range(0, 1)), 8'(ex), 23'($urandom)};
      end
      s = 1'($urandom_range(0, 1));
      issue(x, y, s, ref_add(x, y, s));
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end

    t = 0;
    while (sb_q.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
